// File: rtl/button_ctrl_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_ctrl_debounce
//  Description : Front-end control stage for the divided-clock up/down
//                counter / 7-segment display block. Synchronises and
//                debounces the run/stop, direction and clear push-buttons and
//                turns each accepted press into exactly one control action.
//
//  Ports
//    i_clk        board clock, all logic on the rising edge
//    i_rst        synchronous active-high reset
//    i_btn_run    raw run/stop button (async, active-high, bouncy)
//    i_btn_dir    raw direction button
//    i_btn_clr    raw clear button
//    o_enable     run level to the counter block
//    o_up_down_n  direction level (1 = up, 0 = down)
//    o_cnt_rst_n  active-low clear pulse to the counter block
//    o_btn_level  debounced levels {clr, dir, run}
//
//  Revision    : 1.0  initial release
// ============================================================================
module button_ctrl_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
    parameter int unsigned CLR_PULSE_CYCLES = 4,
    parameter bit          ENABLE_INIT      = 1'b1,
    parameter bit          DIR_INIT         = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_run,
    input  logic       i_btn_dir,
    input  logic       i_btn_clr,
    output logic       o_enable,
    output logic       o_up_down_n,
    output logic       o_cnt_rst_n,
    output logic [2:0] o_btn_level
);

    // Counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]         c_PULSE_LEN = 8'(CLR_PULSE_CYCLES);

    // Debounce FSM encoding
    localparam logic [1:0] c_IDLE_LOW  = 2'd0;
    localparam logic [1:0] c_WAIT_HIGH = 2'd1;
    localparam logic [1:0] c_IDLE_HIGH = 2'd2;
    localparam logic [1:0] c_WAIT_LOW  = 2'd3;

    // Button index order matches o_btn_level: 0 = run, 1 = dir, 2 = clr
    logic [2:0] w_btn_raw;
    logic [2:0] w_press;
    logic [2:0] w_level;

    assign w_btn_raw = {i_btn_clr, i_btn_dir, i_btn_run};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic [1:0]         r_state;
        logic [c_CNT_W-1:0] r_cnt;

        // The press strobe is the WAIT_HIGH -> IDLE_HIGH transition itself,
        // so the action lands on the same edge the FSM accepts the level.
        assign w_press[g] = (r_state == c_WAIT_HIGH) && r_sync2 && (r_cnt == c_CNT_MAX);
        assign w_level[g] = (r_state == c_IDLE_HIGH) || (r_state == c_WAIT_LOW);

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_state <= c_IDLE_LOW;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_btn_raw[g];
                r_sync2 <= r_sync1;
                case (r_state)
                    c_IDLE_LOW: begin
                        if (r_sync2) begin
                            r_state <= c_WAIT_HIGH;
                            r_cnt   <= '0;
                        end
                    end
                    c_WAIT_HIGH: begin
                        // Any low sample throws away the partial interval
                        if (!r_sync2) begin
                            r_state <= c_IDLE_LOW;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_CNT_MAX) begin
                            r_state <= c_IDLE_HIGH;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    c_IDLE_HIGH: begin
                        if (!r_sync2) begin
                            r_state <= c_WAIT_LOW;
                            r_cnt   <= '0;
                        end
                    end
                    c_WAIT_LOW: begin
                        if (r_sync2) begin
                            r_state <= c_IDLE_HIGH;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_CNT_MAX) begin
                            r_state <= c_IDLE_LOW;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE_LOW;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    logic       r_enable;
    logic       r_up_down_n;
    logic       r_cnt_rst_n;
    logic [7:0] r_pulse_cnt;

    // Clear pulse: the strobe edge drives the output low and loads LEN-1, so
    // the low time is exactly LEN cycles. Reset loads LEN instead, because the
    // reset edges themselves do not count toward the post-reset low time.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_enable    <= ENABLE_INIT;
            r_up_down_n <= DIR_INIT;
            r_cnt_rst_n <= 1'b0;
            r_pulse_cnt <= c_PULSE_LEN;
        end else if (w_press[2]) begin
            // Clear wins over any same-cycle run/dir strobe; a clear during
            // an active pulse restarts the low time.
            r_enable    <= ENABLE_INIT;
            r_up_down_n <= DIR_INIT;
            r_cnt_rst_n <= 1'b0;
            r_pulse_cnt <= c_PULSE_LEN - 8'd1;
        end else begin
            if (w_press[0]) begin
                r_enable <= ~r_enable;
            end
            if (w_press[1]) begin
                r_up_down_n <= ~r_up_down_n;
            end
            if (r_pulse_cnt != 8'd0) begin
                r_pulse_cnt <= r_pulse_cnt - 8'd1;
                r_cnt_rst_n <= 1'b0;
            end else begin
                r_cnt_rst_n <= 1'b1;
            end
        end
    end

    assign o_enable    = r_enable;
    assign o_up_down_n = r_up_down_n;
    assign o_cnt_rst_n = r_cnt_rst_n;
    assign o_btn_level = w_level;

endmodule
`default_nettype wire

// File: tb/tb_button_ctrl_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_ctrl_debounce
//  Description : Directed self-checking bench for button_ctrl_debounce with
//                DEBOUNCE_CYCLES=4 and CLR_PULSE_CYCLES=3. Edge numbering in
//                the comments counts the first rising edge that samples a new
//                pin level as edge 0.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_ctrl_debounce;

    logic       clk;
    logic       rst;
    logic       btn_run;
    logic       btn_dir;
    logic       btn_clr;
    logic       enable;
    logic       up_down_n;
    logic       cnt_rst_n;
    logic [2:0] btn_level;

    int n_checks;
    int n_errors;

    button_ctrl_debounce #(
        .DEBOUNCE_CYCLES (4),
        .CLR_PULSE_CYCLES(3),
        .ENABLE_INIT     (1'b1),
        .DIR_INIT        (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_btn_run  (btn_run),
        .i_btn_dir  (btn_dir),
        .i_btn_clr  (btn_clr),
        .o_enable   (enable),
        .o_up_down_n(up_down_n),
        .o_cnt_rst_n(cnt_rst_n),
        .o_btn_level(btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input int en, input int ud,
                               input int rn, input int lvl);
        check_val({tag, ".enable"},    int'(enable),    en);
        check_val({tag, ".up_down_n"}, int'(up_down_n), ud);
        check_val({tag, ".cnt_rst_n"}, int'(cnt_rst_n), rn);
        check_val({tag, ".level"},     int'(btn_level), lvl);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bit dir_pat [6];
        n_checks = 0;
        n_errors = 0;
        dir_pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // ---------------- Reset ----------------
        rst = 1'b1; btn_run = 1'b0; btn_dir = 1'b0; btn_clr = 1'b0;
        step(2);
        expect_outs("reset", 1, 1, 0, 0);
        rst = 1'b0;
        step(1); check_val("post_rst_r0", int'(cnt_rst_n), 0);
        step(1); check_val("post_rst_r1", int'(cnt_rst_n), 0);
        step(1); check_val("post_rst_r2", int'(cnt_rst_n), 0);
        step(1); check_val("post_rst_r3", int'(cnt_rst_n), 1);
        step(2);

        // ---------------- Run press: 20 high, 20 low ----------------
        btn_run = 1'b1;
        step(6);                                  // edges 0..5
        expect_outs("run_e5", 1, 1, 1, 0);
        step(1);                                  // edge 6
        expect_outs("run_e6", 0, 1, 1, 1);
        step(13);                                 // edges 7..19
        expect_outs("run_e19", 0, 1, 1, 1);
        btn_run = 1'b0;                           // low from edge 20
        step(6);                                  // edges 20..25
        expect_outs("run_e25", 0, 1, 1, 1);
        step(1);                                  // edge 26
        expect_outs("run_e26", 0, 1, 1, 0);
        step(14);
        expect_outs("run_rel", 0, 1, 1, 0);

        // ---------------- Dir bounce then stable high ----------------
        for (int i = 0; i < 6; i++) begin
            btn_dir = dir_pat[i];
            step(1);
            check_val("dir_bounce", int'(up_down_n), 1);
        end
        // last pattern entry (1) was the final rise, sampled at edge 0
        step(5);                                  // edges 1..5
        expect_outs("dir_e5", 0, 1, 1, 0);
        step(1);                                  // edge 6
        expect_outs("dir_e6", 0, 0, 1, 2);
        step(6);
        check_val("dir_hold", int'(up_down_n), 0);
        btn_dir = 1'b0;
        step(10);
        expect_outs("dir_rel", 0, 0, 1, 0);

        // ---------------- Clear press ----------------
        btn_clr = 1'b1;
        step(6);
        expect_outs("clr_e5", 0, 0, 1, 0);
        step(1);
        expect_outs("clr_e6", 1, 1, 0, 4);
        step(1); check_val("clr_e7.rn", int'(cnt_rst_n), 0);
        step(1); check_val("clr_e8.rn", int'(cnt_rst_n), 0);
        step(1); check_val("clr_e9.rn", int'(cnt_rst_n), 1);
        btn_clr = 1'b0;
        step(10);
        expect_outs("clr_rel", 1, 1, 1, 0);

        // ---------------- Run + clr together: clear wins ----------------
        btn_run = 1'b1; btn_clr = 1'b1;
        step(6);
        expect_outs("runclr_e5", 1, 1, 1, 0);
        step(1);
        expect_outs("runclr_e6", 1, 1, 0, 5);
        step(2); check_val("runclr_e8.rn", int'(cnt_rst_n), 0);
        step(1); check_val("runclr_e9.rn", int'(cnt_rst_n), 1);
        btn_run = 1'b0; btn_clr = 1'b0;
        step(10);
        expect_outs("runclr_rel", 1, 1, 1, 0);

        // ---------------- Run + dir together: both toggle ----------------
        btn_run = 1'b1; btn_dir = 1'b1;
        step(6);
        expect_outs("rundir_e5", 1, 1, 1, 0);
        step(1);
        expect_outs("rundir_e6", 0, 0, 1, 3);
        btn_run = 1'b0; btn_dir = 1'b0;
        step(10);
        expect_outs("rundir_rel", 0, 0, 1, 0);

        // ---------------- Reset mid-WAIT_HIGH (cnt=2) ----------------
        btn_run = 1'b1;
        step(5);                                  // edges 0..4: WAIT_HIGH, cnt=2
        expect_outs("rstmid_pre", 0, 0, 1, 0);
        rst = 1'b1;
        step(2);                                  // would-be strobe edge is inside reset
        expect_outs("rstmid_rst", 1, 1, 0, 0);
        rst = 1'b0;
        step(3);                                  // R..R+2
        expect_outs("rstmid_r2", 1, 1, 0, 0);
        step(3);                                  // R+3..R+5
        expect_outs("rstmid_r5", 1, 1, 1, 0);
        step(1);                                  // R+6
        expect_outs("rstmid_r6", 0, 1, 1, 1);
        btn_run = 1'b0;
        step(10);
        expect_outs("rstmid_rel", 0, 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
